// File: rtl/up_counter_pkg.sv
// Shared constants and next-state function for the up_counter block.
// Optional build macro: UP_COUNTER_SATURATE_EN (hold at MAX_VAL instead of wrapping).
package up_counter_pkg;

  localparam int unsigned UP_COUNTER_DEFAULT_WIDTH = 32'd4;

  // Priority: clear, then clamped load, then enabled count, else hold.
  function automatic logic [31:0] up_counter_next(
    input logic [31:0] cnt,
    input logic        en,
    input logic        clr,
    input logic        load,
    input logic [31:0] load_val,
    input logic [31:0] max_val
  );
    logic [31:0] nxt;
    nxt = cnt;
    if (clr) begin
      nxt = 32'd0;
    end else if (load) begin
      nxt = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (cnt == max_val) begin
`ifdef UP_COUNTER_SATURATE_EN
        nxt = max_val;
`else
        nxt = 32'd0;
`endif
      end else begin
        nxt = cnt + 32'd1;
      end
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/up_counter_core.sv
// Count register with asynchronous active-high reset and terminal-count compare.
// The next-state value is computed by the enclosing up_counter.
module up_counter_core
  import up_counter_pkg::*;
#(
  parameter int unsigned          WIDTH   = UP_COUNTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] cnt_d_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d_i;
    end
  end

  assign cnt_o = cnt_q;
  // tc follows cnt directly so it changes in the same cycle as the count
  assign tc_o  = (cnt_q == MAX_VAL);

endmodule

// File: rtl/up_counter.sv
// Enable-gated up-counter with synchronous clear, clamped parallel load and tc flag.
// Build macro UP_COUNTER_SATURATE_EN selects saturate-at-MAX_VAL instead of wrap.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int unsigned          WIDTH   = UP_COUNTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  if ((WIDTH < 32'd2) || (WIDTH > 32'd32)) begin : g_bad_width
    $error("up_counter: WIDTH must be in 2..32");
  end
  if (MAX_VAL == {WIDTH{1'b0}}) begin : g_bad_max
    $error("up_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] cnt_d;

  // Clear/load/count priority mux, evaluated at 32 bits then narrowed
  always_comb begin
    cnt_d = WIDTH'(up_counter_next(32'(cnt), en, clr, load,
                                   32'(load_val), 32'(MAX_VAL)));
  end

  up_counter_core #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_core (
    .clk_i   (clk),
    .reset_i (reset),
    .cnt_d_i (cnt_d),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

endmodule

// File: tb/tb_up_counter.sv
// Scoreboard bench for up_counter: three instances (MAX_VAL 15, 10, 5) share stimulus.
module tb_up_counter;

  logic       clk = 1'b0;
  logic       reset, en, clr, load;
  logic [3:0] load_val;
  logic [3:0] cnt0, cnt1, cnt2;
  logic       tc0, tc1, tc2;

  int tests_run = 0;
  int failed    = 0;

  typedef struct packed {
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
  } exp_t;

  exp_t sb[$];
  int   m0, m1, m2;

  always #5 clk = ~clk;

  up_counter #(.WIDTH(4)) dut0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt0), .tc(tc0)
  );
  up_counter #(.WIDTH(4), .MAX_VAL(4'd10)) dut10 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt1), .tc(tc1)
  );
  up_counter #(.WIDTH(4), .MAX_VAL(4'd5)) dut5 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt2), .tc(tc2)
  );

  function automatic int mnext(int c, int mx, bit e, bit cl, bit ld, int lv);
    if (cl) return 0;
    if (ld) return (lv > mx) ? mx : lv;
    if (e) begin
`ifdef UP_COUNTER_SATURATE_EN
      return (c == mx) ? mx : c + 1;
`else
      return (c + 1) % (mx + 1);
`endif
    end
    return c;
  endfunction

  // Drive one cycle at the falling edge, push expectation, land #1 after the rising edge
  task automatic step(bit r, bit e, bit cl, bit ld, logic [3:0] lv);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; clr = cl; load = ld; load_val = lv;
    if (r) begin
      m0 = 0; m1 = 0; m2 = 0;
    end else begin
      m0 = mnext(m0, 15, e, cl, ld, int'(lv));
      m1 = mnext(m1, 10, e, cl, ld, int'(lv));
      m2 = mnext(m2, 5,  e, cl, ld, int'(lv));
    end
    x.c0 = 4'(m0); x.c1 = 4'(m1); x.c2 = 4'(m2);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    #1;
    tests_run++;
    if (cnt0 !== 4'd0 || tc0 !== 1'b0) begin
      failed++;
      $display("FAIL reset_async cnt=%0d tc=%0b expected cnt=0 tc=0", cnt0, tc0);
    end
    for (int i = 0; i < 8; i++) begin
      step((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      x = sb.pop_front();
      tests_run++;
      if (cnt0 !== 4'd0 || tc0 !== 1'b0 || cnt0 !== x.c0) begin
        failed++;
        $display("FAIL reset_hold[%0d] cnt=%0d tc=%0b expected cnt=0 tc=0", i, cnt0, tc0);
      end
    end
  endtask

  task automatic test_count_window();
    exp_t x;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, (i < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0, 4'd0);
      x = sb.pop_front();
      tests_run++;
      if (cnt0 !== x.c0 || tc0 !== (x.c0 == 4'd15)) begin
        failed++;
        $display("FAIL count_window[%0d] cnt=%0d tc=%0b expected cnt=%0d tc=%0b",
                 i, cnt0, tc0, x.c0, (x.c0 == 4'd15));
      end
    end
  endtask

  task automatic test_wrap();
    exp_t x;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, (i > 0) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b0, 4'd0);
      x = sb.pop_front();
      tests_run++;
      if (cnt0 !== x.c0 || tc0 !== (x.c0 == 4'd15)) begin
        failed++;
        $display("FAIL wrap[%0d] cnt=%0d tc=%0b expected cnt=%0d tc=%0b",
                 i, cnt0, tc0, x.c0, (x.c0 == 4'd15));
      end
    end
    tests_run++;
`ifdef UP_COUNTER_SATURATE_EN
    if (cnt0 !== 4'd15 || tc0 !== 1'b1) begin
      failed++;
      $display("FAIL wrap_end cnt=%0d tc=%0b expected cnt=15 tc=1", cnt0, tc0);
    end
`else
    if (cnt0 !== 4'd1 || tc0 !== 1'b0) begin
      failed++;
      $display("FAIL wrap_end cnt=%0d tc=%0b expected cnt=1 tc=0", cnt0, tc0);
    end
`endif
  endtask

  task automatic test_load_priority();
    exp_t x;
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    x = sb.pop_front();
    tests_run++;
    if (cnt0 !== x.c0 || cnt2 !== x.c2 || tc2 !== (x.c2 == 4'd5)) begin
      failed++;
      $display("FAIL load_en cnt=%0d cnt5=%0d tc5=%0b expected cnt=%0d cnt5=%0d",
               cnt0, cnt2, tc2, x.c0, x.c2);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    x = sb.pop_front();
    tests_run++;
    if (cnt0 !== x.c0 || tc0 !== 1'b0) begin
      failed++;
      $display("FAIL clr_over_load cnt=%0d expected cnt=%0d", cnt0, x.c0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    x = sb.pop_front();
    tests_run++;
    if (cnt0 !== x.c0 || cnt1 !== x.c1) begin
      failed++;
      $display("FAIL clr_load_en cnt=%0d cnt10=%0d expected cnt=%0d cnt10=%0d",
               cnt0, cnt1, x.c0, x.c1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd13);
    x = sb.pop_front();
    tests_run++;
    if (cnt1 !== x.c1 || tc1 !== (x.c1 == 4'd10) || cnt0 !== x.c0) begin
      failed++;
      $display("FAIL load_clamp cnt10=%0d tc10=%0b cnt=%0d expected cnt10=%0d cnt=%0d",
               cnt1, tc1, cnt0, x.c1, x.c0);
    end
  endtask

  task automatic test_async_reset();
    exp_t x;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i > 0) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b0, 4'd0);
      x = sb.pop_front();
      tests_run++;
      if (cnt0 !== x.c0) begin
        failed++;
        $display("FAIL pre_reset[%0d] cnt=%0d expected cnt=%0d", i, cnt0, x.c0);
      end
    end
    #3 reset = 1'b1;
    #1;
    tests_run++;
    if (cnt0 !== 4'd0 || tc0 !== 1'b0 || cnt1 !== 4'd0 || cnt2 !== 4'd0) begin
      failed++;
      $display("FAIL async_reset cnt=%0d cnt10=%0d cnt5=%0d expected all 0",
               cnt0, cnt1, cnt2);
    end
    m0 = 0; m1 = 0; m2 = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    x = sb.pop_front();
    tests_run++;
    if (cnt0 !== 4'd0 || cnt0 !== x.c0) begin
      failed++;
      $display("FAIL reset_held cnt=%0d expected cnt=0", cnt0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    x = sb.pop_front();
    tests_run++;
    if (cnt0 !== 4'd1 || cnt0 !== x.c0) begin
      failed++;
      $display("FAIL first_after_release cnt=%0d expected cnt=1", cnt0);
    end
  endtask

  task automatic test_max5();
    exp_t x;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, (i > 0) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b0, 4'd0);
      x = sb.pop_front();
      tests_run++;
      if (cnt2 !== x.c2 || tc2 !== (x.c2 == 4'd5)) begin
        failed++;
        $display("FAIL max5[%0d] cnt=%0d tc=%0b expected cnt=%0d tc=%0b",
                 i, cnt2, tc2, x.c2, (x.c2 == 4'd5));
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    m0 = 0; m1 = 0; m2 = 0;
    test_reset();
    test_count_window();
    test_wrap();
    test_load_priority();
    test_async_reset();
    test_max5();
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_left size=%0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
